// File: rtl/mac_rx_type_router.sv
`default_nettype none
// ============================================================================
// mac_rx_type_router : store-and-forward ethertype demux of a MAC RX stream.
// Optional discard counters are built when MAC_RX_ROUTER_STATS_EN is defined.
// Revision 1.0 - initial release
// ============================================================================
module mac_rx_type_router #(
  parameter int                       P_CHANNELS  = 2,
  parameter logic [16*P_CHANNELS-1:0] P_TYPE_LIST = {16'h0806, 16'h0800},
  parameter int                       P_BUF_AW    = 11,
  parameter int                       P_CRC_CHECK = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [15:0]             i_pre_type,
  input  logic [7:0]              i_pre_data,
  input  logic                    i_pre_valid,
  input  logic                    i_pre_last,
  input  logic                    i_pre_crc_error,
  input  logic                    i_pre_crc_valid,
  output logic [8*P_CHANNELS-1:0] o_ch_data,
  output logic [P_CHANNELS-1:0]   o_ch_valid,
  output logic [P_CHANNELS-1:0]   o_ch_last,
  output logic [15:0]             o_drop_crc_cnt,
  output logic [15:0]             o_drop_type_cnt,
  output logic [15:0]             o_drop_ovf_cnt
);

  localparam logic [P_BUF_AW:0] PTR_ONE = {{P_BUF_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_WAIT_CRC, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} rstate_t;

  wstate_t           w_state, w_next;
  rstate_t           r_state, r_next;

  logic [7:0]        mem [0:(1<<P_BUF_AW)-1];
  logic [P_BUF_AW:0] wr_ptr, start_ptr, rd_ptr, used;
  logic              buf_full;
  logic [15:0]       len_cnt, len_inc, commit_len;
  logic [1:0]        frame_ch, commit_ch, type_ch;
  logic              type_hit;
  logic [3:0]        crc_timer;
  logic              wr_en, commit, drop_crc, drop_type, drop_ovf, discard;

  logic [15:0]       desc_len [0:3];
  logic [1:0]        desc_ch [0:3];
  logic [1:0]        desc_wp, desc_rp;
  logic [2:0]        desc_cnt;
  logic              desc_full, desc_empty;

  logic [15:0]       remain;
  logic              load, pop, load_last;
  logic [7:0]        out_byte;
  logic              out_valid, out_last;
  logic [1:0]        out_ch;

  // Pointers carry one extra bit so a completely full buffer is distinguishable from empty.
  assign used       = wr_ptr - rd_ptr;
  assign buf_full   = used[P_BUF_AW];
  assign desc_full  = desc_cnt[2];
  assign desc_empty = (desc_cnt == 3'd0);
  assign len_inc    = (w_state == W_IDLE) ? 16'd1 : len_cnt + 16'd1;
  assign commit_len = wr_en ? len_inc : len_cnt;
  assign commit_ch  = (w_state == W_IDLE) ? type_ch : frame_ch;
  assign discard    = drop_crc | drop_type | drop_ovf;

  // Descending scan so the lowest matching channel ends up selected.
  always_comb begin
    type_hit = 1'b0;
    type_ch  = 2'd0;
    for (int i = P_CHANNELS - 1; i >= 0; i--) begin
      if (i_pre_type == P_TYPE_LIST[16*i +: 16]) begin
        type_hit = 1'b1;
        type_ch  = 2'(i);
      end
    end
  end

  always_comb begin
    w_next    = w_state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    drop_crc  = 1'b0;
    drop_type = 1'b0;
    drop_ovf  = 1'b0;
    case (w_state)
      W_IDLE: if (i_pre_valid) begin
        if (!type_hit) begin
          drop_type = 1'b1;
          w_next    = i_pre_last ? W_IDLE : W_DROP;
        end else if (buf_full || desc_full) begin
          drop_ovf = 1'b1;
          w_next   = i_pre_last ? W_IDLE : W_DROP;
        end else begin
          wr_en  = 1'b1;
          w_next = W_RECV;
        end
      end
      W_RECV: if (i_pre_valid) begin
        if (buf_full) begin
          drop_ovf = 1'b1;
          w_next   = i_pre_last ? W_IDLE : W_DROP;
        end else begin
          wr_en = 1'b1;
        end
      end
      W_WAIT_CRC: if (i_pre_crc_valid) begin
        commit   = !i_pre_crc_error;
        drop_crc = i_pre_crc_error;
        w_next   = W_IDLE;
      end else if (crc_timer == 4'd15) begin
        drop_crc = 1'b1;
        w_next   = W_IDLE;
      end
      W_DROP: if (i_pre_valid && i_pre_last) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    // A verdict arriving together with the last byte is resolved immediately.
    if (wr_en && i_pre_last) begin
      if (P_CRC_CHECK == 0) begin
        commit = 1'b1;
        w_next = W_IDLE;
      end else if (i_pre_crc_valid) begin
        commit   = !i_pre_crc_error;
        drop_crc = i_pre_crc_error;
        w_next   = W_IDLE;
      end else begin
        w_next = W_WAIT_CRC;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state   <= W_IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      len_cnt   <= 16'd0;
      frame_ch  <= 2'd0;
      crc_timer <= 4'd0;
    end else begin
      w_state   <= w_next;
      crc_timer <= (w_state == W_WAIT_CRC) ? crc_timer + 4'd1 : 4'd0;
      if (wr_en) len_cnt <= len_inc;
      if (w_state == W_IDLE) frame_ch <= type_ch;
      if (discard) wr_ptr <= start_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit) start_ptr <= wr_en ? wr_ptr + PTR_ONE : wr_ptr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[P_BUF_AW-1:0]] <= i_pre_data;
    if (commit) begin
      desc_len[desc_wp] <= commit_len;
      desc_ch[desc_wp]  <= commit_ch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      desc_wp  <= 2'd0;
      desc_rp  <= 2'd0;
      desc_cnt <= 3'd0;
    end else begin
      if (commit) desc_wp <= desc_wp + 2'd1;
      if (pop) desc_rp <= desc_rp + 2'd1;
      desc_cnt <= desc_cnt + {2'b00, commit} - {2'b00, pop};
    end
  end

  always_comb begin
    r_next    = r_state;
    pop       = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    case (r_state)
      R_IDLE: if (!desc_empty) begin
        pop       = 1'b1;
        load      = 1'b1;
        load_last = (desc_len[desc_rp] == 16'd1);
        r_next    = load_last ? R_GAP : R_SEND;
      end
      R_SEND: begin
        load      = 1'b1;
        load_last = (remain == 16'd1);
        if (load_last) r_next = R_GAP;
      end
      R_GAP:   r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= R_IDLE;
      rd_ptr    <= '0;
      remain    <= 16'd0;
      out_byte  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= 2'd0;
    end else begin
      r_state   <= r_next;
      out_valid <= load;
      out_last  <= load && load_last;
      out_byte  <= load ? mem[rd_ptr[P_BUF_AW-1:0]] : 8'd0;
      if (pop) begin
        out_ch <= desc_ch[desc_rp];
        remain <= desc_len[desc_rp] - 16'd1;
      end else if (load) begin
        remain <= remain - 16'd1;
      end
      if (load) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel                = out_valid && (out_ch == 2'(g));
    assign o_ch_valid[g]      = sel;
    assign o_ch_last[g]       = sel && out_last;
    assign o_ch_data[8*g +: 8] = sel ? out_byte : 8'd0;
  end

`ifdef MAC_RX_ROUTER_STATS_EN
  logic [15:0] cnt_crc, cnt_type, cnt_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_crc  <= 16'd0;
      cnt_type <= 16'd0;
      cnt_ovf  <= 16'd0;
    end else begin
      if (drop_crc && cnt_crc != 16'hFFFF) cnt_crc <= cnt_crc + 16'd1;
      if (drop_type && cnt_type != 16'hFFFF) cnt_type <= cnt_type + 16'd1;
      if (drop_ovf && cnt_ovf != 16'hFFFF) cnt_ovf <= cnt_ovf + 16'd1;
    end
  end

  assign o_drop_crc_cnt  = cnt_crc;
  assign o_drop_type_cnt = cnt_type;
  assign o_drop_ovf_cnt  = cnt_ovf;
`else
  assign o_drop_crc_cnt  = 16'd0;
  assign o_drop_type_cnt = 16'd0;
  assign o_drop_ovf_cnt  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/mac_rx_type_router.md
MAC_RX_TYPE_ROUTER -- requirements
Module: mac_rx_type_router

Interface
REQ-001 SHALL have parameter P_CHANNELS, default 2: number of output channels, legal range 1..4.
REQ-002 SHALL have parameter P_TYPE_LIST, default {16'h0806,16'h0800}: ethertype per channel, 16 bits each, channel 0 in bits [15:0].
REQ-003 SHALL have parameter P_BUF_AW, default 11: frame buffer address width, depth 2^P_BUF_AW bytes.
REQ-004 SHALL have parameter P_CRC_CHECK, default 1: 1 = commit gated by CRC result, 0 = commit at last byte.
REQ-005 SHALL have port i_clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-007 SHALL have ports i_pre_type  input  16, i_pre_data  input  8, i_pre_valid  input  1, i_pre_last  input  1: MAC RX payload stream; type stable while valid.
REQ-008 SHALL have ports i_pre_crc_error  input  1, i_pre_crc_valid  input  1: CRC verdict, one-cycle pulse.
REQ-009 SHALL have ports o_ch_data  output  8*P_CHANNELS, o_ch_valid  output  P_CHANNELS, o_ch_last  output  P_CHANNELS: per-channel byte stream, channel i in slice i.
REQ-010 SHALL have ports o_drop_crc_cnt, o_drop_type_cnt, o_drop_ovf_cnt  output  16 each: saturating discard counters.

Function
REQ-011 SHALL store frames store-and-forward; no byte reaches any o_ch_* before its frame commits.
REQ-012 SHALL run write FSM W_IDLE -> W_RECV on first i_pre_valid; W_RECV -> W_WAIT_CRC on i_pre_last (P_CRC_CHECK=1) or -> commit and W_IDLE (P_CRC_CHECK=0).
REQ-013 SHALL in W_WAIT_CRC commit on i_pre_crc_valid with i_pre_crc_error=0, discard with error=1; crc_valid coincident with i_pre_last SHALL be honoured.
REQ-014 SHALL discard a frame if no i_pre_crc_valid within 16 cycles after i_pre_last, counted as CRC drop.
REQ-015 SHALL sample i_pre_type on the first byte and match against P_TYPE_LIST; lowest matching channel wins; no match marks frame for discard counted in o_drop_type_cnt, bytes not stored.
REQ-016 SHALL discard a frame when buffer free space reaches 0 or descriptor FIFO is full at first byte; enter W_DROP until i_pre_last, counted in o_drop_ovf_cnt.
REQ-017 SHALL discard by rolling the write pointer back to the frame start pointer; committed frames never corrupted.
REQ-018 SHALL push descriptor {length 16b, channel index} into a 4-entry descriptor FIFO on commit.
REQ-019 SHALL run read FSM R_IDLE -> R_SEND when descriptor FIFO non-empty; R_SEND outputs length bytes contiguously on the addressed channel, o_ch_last on the final byte; R_SEND -> R_GAP -> R_IDLE, one idle cycle between frames.
REQ-020 SHALL present first output byte 2 cycles after the commit cycle when read FSM is idle.
REQ-021 SHALL keep o_ch_data at 0 and o_ch_valid/o_ch_last low on inactive channels; at most one channel valid per cycle.
REQ-022 SHALL handle simultaneous write and read each cycle (dual-port buffer); pointers wrap modulo 2^P_BUF_AW.
REQ-023 SHALL emit a 1-byte frame with o_ch_valid and o_ch_last in the same cycle.
REQ-024 SHALL increment each counter by 1 per discarded frame, saturating at 16'hFFFF.

Reset
REQ-025 SHALL on i_rst clear both FSMs to idle, pointers, descriptor FIFO, counters; all outputs 0 next cycle.
REQ-026 SHALL on reset mid-frame abandon input and output frames without emitting o_ch_last.

Configuration
REQ-027 SHALL compile counters only when macro MAC_RX_ROUTER_STATS_EN is defined; without it the three counter outputs SHALL be constant 0, discard behaviour unchanged.

Verification
REQ-028 SHALL cover: 64-byte type 16'h0800 frame, crc_error=0 -> 64 bytes on channel 0, last on byte 64, channel 1 silent.
REQ-029 SHALL cover: 46-byte type 16'h0806 frame, crc_error=1 -> no output, o_drop_crc_cnt=1.
REQ-030 SHALL cover: type 16'h86DD frame -> no output, o_drop_type_cnt=1; next valid IP frame delivered intact.
REQ-031 SHALL cover: P_BUF_AW=6, 80-byte frame -> dropped, o_drop_ovf_cnt=1; following 20-byte frame delivered.
REQ-032 SHALL cover: three back-to-back committed frames 0800/0806/0800 -> delivered in order with single idle gaps.
REQ-033 SHALL cover: i_rst asserted at output byte 10 -> outputs 0 next cycle, counters 0, subsequent frame delivered normally.
